instr_fetch: RTL
================

# instr_fetch

Instruction-fetch stage feeding the instruction decoder: owns the program counter, issues word reads to instruction memory over a req/ack handshake, and presents fetched 32-bit instructions with their PC on a valid/ready interface into the ID stage. A two-entry buffer decouples memory latency from decoder stalls. A redirect input from branch/jump resolution flushes in-flight work and restarts fetch at a new PC.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- clk  in  1  rising-edge clock for all state
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  read request; registered; held high until imem_ack
- imem_addr  out  32  word-aligned fetch address; registered; stable while imem_req=1
- imem_ack  in  1  request accepted and imem_rdata valid this cycle
- imem_rdata  in  32  instruction word, sampled only when imem_req & imem_ack
- instr_valid  out  1  instr_out/pc_out hold a valid instruction
- instr_out  out  32  instruction to ID stage
- pc_out  out  32  address instr_out was fetched from
- id_ready  in  1  ID stage accepts; transfer when instr_valid & id_ready
- redirect_valid  in  1  one-cycle pulse: flush and restart fetch
- redirect_pc  in  32  new fetch address; bits [1:0] forced to 0 internally

## Operation
- Reset (rst=1 at an edge): fetch_pc=RESET_PC, buffer empty, imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr_out=0, pc_out=0, state=RUN.
- Buffer: 2-entry FIFO of {pc, instr}; head drives instr_out/pc_out; instr_valid = not empty.
- Slot reservation: a request may start only if count + outstanding < 2 (outstanding = imem_req currently high); guarantees every ack has a free slot, no backpressure on memory.
- RUN: if imem_req=0 and slot free → next cycle imem_req=1, imem_addr=fetch_pc. On imem_req&imem_ack: push {imem_addr, imem_rdata}, fetch_pc += 4; if slot still free after this cycle's push/pop → keep imem_req=1 with imem_addr=fetch_pc+4 (back-to-back), else drop imem_req.
- PC arithmetic: 32-bit, modulo 2^32; 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
- Redirect (redirect_valid=1), priority over everything except rst:
  - Buffer flushed the same edge (instr_valid=0 next cycle); a simultaneous pop is still a valid transfer for that cycle.
  - fetch_pc ← {redirect_pc[31:2],2'b00}.
  - If imem_req=1 and imem_ack=0 → state DRAIN: imem_req stays high with old address (handshake must not be abandoned).
  - If imem_req=1 and imem_ack=1 same cycle → response discarded, no push; stay RUN.
  - If imem_req=0 → stay RUN; new request next cycle.
- DRAIN: imem_req held; on imem_ack, data discarded, imem_req drops, → RUN; new request issues the following cycle. A further redirect in DRAIN only updates fetch_pc (last redirect wins).
- Simultaneous push and pop: both take effect; count unchanged.
- rst mid-transaction: abandons outstanding request (memory side is reset with the same rst).

## Timing
- First imem_req=1 in the cycle after rst deasserts.
- Ack at edge N → instr_valid=1 from cycle N+1 (latency 1 from ack).
- Zero-wait memory, id_ready=1: one instruction per cycle steady state; imem_req stays continuously high.
- Redirect at edge N, no outstanding request: imem_req=1 with redirect address at cycle N+1; first redirected instruction valid at earliest N+2.
- Redirect with pending request: extra latency = remaining cycles to ack + 1.
- instr_out/pc_out stable while instr_valid=1 and id_ready=0.

## Structure
- Shared package: PC width (32), instruction width (32), PC increment (4), default RESET_PC, state encoding {RUN, DRAIN}.
- Sub-module fetch_fifo2: 2-entry {pc,instr} FIFO with push, pop, flush, count[1:0], head outputs; flush has priority over push.
- Top holds fetch_pc, request register, state machine, slot-reservation logic.

## Test plan
- Reset: hold rst 3 cycles with RESET_PC=32'h0040_0000 → all outputs at reset values; cycle after release imem_req=1, imem_addr=32'h0040_0000.
- Back-to-back: ack every cycle, id_ready=1, rdata = addr ^ 32'hA5A5_A5A5 → pc_out 0x400000, 0x400004, 0x400008… one per cycle, instr_out matches.
- Backpressure: id_ready=0 → after two acks imem_req drops, instr_out holds first word; id_ready=1 → one pop per cycle, request reissues, order preserved, no loss/duplicate.
- Redirect while waiting: ack withheld, redirect_pc=32'h0000_1003 → imem_req stays high on old addr until ack, ack data never appears; next request at 32'h0000_1000.
- Redirect coincident with ack and buffer non-empty → buffer flushed, acked word dropped, next pc_out=redirect target.
- Wrap: RESET_PC=32'hFFFF_FFF8 → pc_out sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: widths, PC increment, default reset PC, fetch FSM
// states and the {pc, instr} buffer entry shared by the fetch stage.
package instr_fetch_pkg;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] PC_INC           = 32'd4;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // RUN: normal fetching. DRAIN: waiting out a request issued before a
    // redirect; its response is thrown away.
    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo2.sv
// fetch_fifo2: two-entry {pc, instr} FIFO between memory and decoder.
//   clk, rst  : clock, synchronous active-high reset (clears storage too)
//   push, din : write an entry (caller guarantees a free slot)
//   pop       : drop the head (caller guarantees count != 0)
//   flush     : empty the FIFO; wins over push and pop
//   head      : oldest entry
//   count     : occupancy, 0..2
module fetch_fifo2
    import instr_fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output fetch_entry_t head,
    output logic [1:0]   count
);
    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, issues word reads over imem_req/imem_ack and
// hands {pc, instr} to the decoder over instr_valid/id_ready through a
// two-entry buffer. redirect_valid flushes and restarts at redirect_pc.
//   clk, rst                  : clock, synchronous active-high reset
//   imem_req/addr (out)       : registered read request, held until ack
//   imem_ack/rdata (in)       : request accepted, data valid this cycle
//   instr_valid/out, pc_out   : buffer head toward the decoder
//   id_ready (in)             : decoder accepts the head
//   redirect_valid/pc (in)    : one-cycle restart request
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    input  logic               id_ready,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc
);
    fetch_state_t    state, state_nx;
    logic [PC_W-1:0] fetch_pc, fetch_pc_nx, addr_nx;
    logic [PC_W-1:0] target, pc_plus;
    logic            req_nx, ack_hit, push, pop, flush;
    logic [1:0]      count;
    logic [2:0]      count_after;
    fetch_entry_t    head;

    assign target      = redirect_pc & ~PC_W'(3);
    assign pc_plus     = fetch_pc + PC_INC;
    assign ack_hit     = imem_req & imem_ack;
    assign instr_valid = (count != 2'd0);
    assign pop         = instr_valid & id_ready;
    assign instr_out   = head.instr;
    assign pc_out      = head.pc;
    // Occupancy after a push this cycle; only meaningful on an ack.
    assign count_after = {1'b0, count} + 3'd1 - {2'b0, pop};

    fetch_fifo2 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ('{pc: imem_addr, instr: imem_rdata}),
        .head  (head),
        .count (count)
    );

    // While a request is live in RUN, fetch_pc == imem_addr. A new request
    // starts only when the buffer will still have a slot for its data, so
    // an ack can always be pushed.
    always_comb begin
        state_nx    = state;
        req_nx      = imem_req;
        addr_nx     = imem_addr;
        fetch_pc_nx = fetch_pc;
        push        = 1'b0;
        flush       = 1'b0;
        unique case (state)
            RUN: begin
                if (redirect_valid) begin
                    flush       = 1'b1;
                    fetch_pc_nx = target;
                    if (imem_req && !imem_ack) begin
                        // handshake cannot be abandoned; wait it out
                        state_nx = DRAIN;
                    end else begin
                        // buffer is empty after the flush: restart at once
                        req_nx  = 1'b1;
                        addr_nx = target;
                    end
                end else if (ack_hit) begin
                    push        = 1'b1;
                    fetch_pc_nx = pc_plus;
                    if (count_after < 3'd2) begin
                        req_nx  = 1'b1;
                        addr_nx = pc_plus;
                    end else begin
                        req_nx = 1'b0;
                    end
                end else if (!imem_req && count < 2'd2) begin
                    req_nx  = 1'b1;
                    addr_nx = fetch_pc;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    flush       = 1'b1;
                    fetch_pc_nx = target;
                end
                if (imem_ack) begin
                    req_nx   = 1'b0;
                    state_nx = RUN;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_nx;
            fetch_pc  <= fetch_pc_nx;
            imem_req  <= req_nx;
            imem_addr <= addr_nx;
        end
    end
endmodule
